// File: rtl/tex_dcr_unit.sv
// DCR front end for the texture unit: decodes host DCR writes into per-stage
// texture state and serves a packed state record through a one-deep lookup port.
module tex_dcr_unit #(
    parameter int          NUM_STAGES  = 2,
    parameter int          LOD_MAX     = 11,
    parameter int          LOD_BITS    = 4,
    parameter int          DIM_BITS    = 11,
    parameter logic [11:0] DCR_BASE    = 12'h100,
    parameter int          TAG_WIDTH   = 8,
    localparam int         STAGE_BITS  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    localparam int         MIPOFF_BITS = 2*DIM_BITS + 1,
    localparam int         DCRS_BITS   = (LOD_MAX+1)*MIPOFF_BITS + 2*LOD_BITS + 4 + 32 + 3 + 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_dcr_wr_valid,
    input  logic [11:0]           i_dcr_wr_addr,
    input  logic [31:0]           i_dcr_wr_data,
    input  logic                  i_req_valid,
    input  logic [STAGE_BITS-1:0] i_req_stage,
    input  logic [TAG_WIDTH-1:0]  i_req_tag,
    output logic                  o_req_ready,
    output logic                  o_rsp_valid,
    output logic [DCRS_BITS-1:0]  o_rsp_dcrs,
    output logic [TAG_WIDTH-1:0]  o_rsp_tag,
    input  logic                  i_rsp_ready,
    output logic [7:0]            o_bad_wr_count
);

    localparam logic [11:0] LAST_OFF = 12'(6 + LOD_MAX);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [31:0]            r_baddr  [NUM_STAGES];
    logic [2:0]             r_format [NUM_STAGES];
    logic                   r_filter [NUM_STAGES];
    logic [1:0]             r_wrap_u [NUM_STAGES];
    logic [1:0]             r_wrap_v [NUM_STAGES];
    logic [LOD_BITS-1:0]    r_log_u  [NUM_STAGES];
    logic [LOD_BITS-1:0]    r_log_v  [NUM_STAGES];
    logic [MIPOFF_BITS-1:0] r_mipoff [NUM_STAGES][LOD_MAX+1];

    // r_stage_bad remembers a full-width out-of-range select, which the
    // truncated r_stage_sel alone could not represent.
    logic [STAGE_BITS-1:0]  r_stage_sel;
    logic                   r_stage_bad;
    logic [7:0]             r_bad_cnt;

    logic                   r_rsp_vld_p1;
    logic [DCRS_BITS-1:0]   r_rsp_dcrs_p1;
    logic [TAG_WIDTH-1:0]   r_rsp_tag_p1;

    logic [11:0]            w_off;
    logic                   w_in_win;
    logic                   w_sel_wr;
    logic                   w_field_wr;
    logic                   w_drop;
    logic                   w_req_ok;
    logic                   w_accept;
    logic [(LOD_MAX+1)*MIPOFF_BITS-1:0] w_mip_pack;
    logic [DCRS_BITS-1:0]   w_rd_dcrs;

    assign w_off      = i_dcr_wr_addr - DCR_BASE;
    assign w_in_win   = i_dcr_wr_valid && (i_dcr_wr_addr >= DCR_BASE) && (w_off <= LAST_OFF);
    assign w_sel_wr   = w_in_win && (w_off == 12'd0);
    assign w_field_wr = w_in_win && (w_off != 12'd0);
    assign w_drop     = w_field_wr && r_stage_bad;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stage_sel <= '0;
            r_stage_bad <= 1'b0;
            r_bad_cnt   <= 8'd0;
        end else begin
            if (w_sel_wr) begin
                r_stage_sel <= i_dcr_wr_data[STAGE_BITS-1:0];
                r_stage_bad <= (i_dcr_wr_data >= 32'(NUM_STAGES));
            end
            if (w_drop)
                r_bad_cnt <= sat_inc8(r_bad_cnt);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                r_baddr[s]  <= '0;
                r_format[s] <= '0;
                r_filter[s] <= 1'b0;
                r_wrap_u[s] <= '0;
                r_wrap_v[s] <= '0;
                r_log_u[s]  <= '0;
                r_log_v[s]  <= '0;
                for (int l = 0; l <= LOD_MAX; l++)
                    r_mipoff[s][l] <= '0;
            end
        end else if (w_field_wr && !r_stage_bad) begin
            case (w_off)
                12'd1: r_baddr[r_stage_sel]  <= i_dcr_wr_data;
                12'd2: begin
                    r_log_u[r_stage_sel] <= i_dcr_wr_data[LOD_BITS-1:0];
                    r_log_v[r_stage_sel] <= i_dcr_wr_data[16+LOD_BITS-1:16];
                end
                12'd3: r_format[r_stage_sel] <= i_dcr_wr_data[2:0];
                12'd4: r_filter[r_stage_sel] <= i_dcr_wr_data[0];
                12'd5: begin
                    r_wrap_u[r_stage_sel] <= i_dcr_wr_data[1:0];
                    r_wrap_v[r_stage_sel] <= i_dcr_wr_data[17:16];
                end
                default: begin
                    for (int l = 0; l <= LOD_MAX; l++)
                        if (w_off == 12'(6 + l))
                            r_mipoff[r_stage_sel][l] <= i_dcr_wr_data[MIPOFF_BITS-1:0];
                end
            endcase
        end
    end

    // Read mux sees pre-edge state, so a same-cycle write is not observed.
    assign w_req_ok = (32'(i_req_stage) < 32'(NUM_STAGES));

    always_comb begin
        w_mip_pack = '0;
        w_rd_dcrs  = '0;
        if (w_req_ok) begin
            for (int l = 0; l <= LOD_MAX; l++)
                w_mip_pack[l*MIPOFF_BITS +: MIPOFF_BITS] = r_mipoff[i_req_stage][l];
            w_rd_dcrs = {w_mip_pack,
                         r_log_v[i_req_stage], r_log_u[i_req_stage],
                         r_wrap_v[i_req_stage], r_wrap_u[i_req_stage],
                         r_baddr[i_req_stage], r_format[i_req_stage],
                         r_filter[i_req_stage]};
        end
    end

    assign o_req_ready = !r_rsp_vld_p1 || i_rsp_ready;
    assign w_accept    = i_req_valid && o_req_ready;

    // Stage p1: single response register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rsp_vld_p1  <= 1'b0;
            r_rsp_dcrs_p1 <= '0;
            r_rsp_tag_p1  <= '0;
        end else if (w_accept) begin
            r_rsp_vld_p1  <= 1'b1;
            r_rsp_dcrs_p1 <= w_rd_dcrs;
            r_rsp_tag_p1  <= i_req_tag;
        end else if (i_rsp_ready) begin
            r_rsp_vld_p1  <= 1'b0;
        end
    end

    assign o_rsp_valid    = r_rsp_vld_p1;
    assign o_rsp_dcrs     = r_rsp_dcrs_p1;
    assign o_rsp_tag      = r_rsp_tag_p1;
    assign o_bad_wr_count = r_bad_cnt;

endmodule

// File: tb/tb_tex_dcr_unit.sv
// Self-checking bench for tex_dcr_unit against a field-level model of the DCR
// register map and the one-deep lookup port.
module tb_tex_dcr_unit;

    localparam int DCRS_BITS = 324;
    localparam int BASE      = 'h100;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 dcr_wr_valid = 1'b0;
    logic [11:0]          dcr_wr_addr = '0;
    logic [31:0]          dcr_wr_data = '0;
    logic                 req_valid = 1'b0;
    logic [0:0]           req_stage = '0;
    logic [7:0]           req_tag = '0;
    logic                 req_ready;
    logic                 rsp_valid;
    logic [DCRS_BITS-1:0] rsp_dcrs;
    logic [7:0]           rsp_tag;
    logic                 rsp_ready = 1'b1;
    logic [7:0]           bad_wr_count;

    int checks = 0;
    int errors = 0;

    tex_dcr_unit dut (
        .i_clk(clk), .i_reset(reset),
        .i_dcr_wr_valid(dcr_wr_valid), .i_dcr_wr_addr(dcr_wr_addr), .i_dcr_wr_data(dcr_wr_data),
        .i_req_valid(req_valid), .i_req_stage(req_stage), .i_req_tag(req_tag),
        .o_req_ready(req_ready), .o_rsp_valid(rsp_valid), .o_rsp_dcrs(rsp_dcrs),
        .o_rsp_tag(rsp_tag), .i_rsp_ready(rsp_ready), .o_bad_wr_count(bad_wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
        $fatal(1, "watchdog");
    end

    // Reference model: one record of named fields per stage.
    logic [31:0] m_baddr [2];
    logic [2:0]  m_fmt   [2];
    logic        m_filt  [2];
    logic [1:0]  m_wu    [2];
    logic [1:0]  m_wv    [2];
    logic [3:0]  m_lu    [2];
    logic [3:0]  m_lv    [2];
    logic [22:0] m_mip   [2][12];
    longint      m_sel;
    int          m_bad;

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_baddr[s] = 0; m_fmt[s] = 0; m_filt[s] = 0;
            m_wu[s] = 0; m_wv[s] = 0; m_lu[s] = 0; m_lv[s] = 0;
            for (int l = 0; l < 12; l++) m_mip[s][l] = 0;
        end
        m_sel = 0;
        m_bad = 0;
    endtask

    task automatic model_write(input int addr, input logic [31:0] data);
        int off;
        int s;
        if (addr < BASE || addr > BASE + 17) return;
        off = addr - BASE;
        if (off == 0) begin
            m_sel = longint'(data);
            return;
        end
        if (m_sel >= 2) begin
            if (m_bad < 255) m_bad++;
            return;
        end
        s = int'(m_sel);
        case (off)
            1: m_baddr[s] = data;
            2: begin m_lu[s] = data[3:0]; m_lv[s] = data[19:16]; end
            3: m_fmt[s] = data[2:0];
            4: m_filt[s] = data[0];
            5: begin m_wu[s] = data[1:0]; m_wv[s] = data[17:16]; end
            default: m_mip[s][off-6] = data[22:0];
        endcase
    endtask

    function automatic logic [DCRS_BITS-1:0] model_pack(input int s);
        logic [DCRS_BITS-1:0] r;
        r = '0;
        if (s >= 2) return r;
        for (int l = 11; l >= 0; l--) r = (r << 23) | DCRS_BITS'(m_mip[s][l]);
        r = (r << 4)  | DCRS_BITS'(m_lv[s]);
        r = (r << 4)  | DCRS_BITS'(m_lu[s]);
        r = (r << 2)  | DCRS_BITS'(m_wv[s]);
        r = (r << 2)  | DCRS_BITS'(m_wu[s]);
        r = (r << 32) | DCRS_BITS'(m_baddr[s]);
        r = (r << 3)  | DCRS_BITS'(m_fmt[s]);
        r = (r << 1)  | DCRS_BITS'(m_filt[s]);
        return r;
    endfunction

    logic [DCRS_BITS-1:0] g_exp;
    bit                   g_acc;

    // One clock cycle with optional DCR write and optional lookup; model follows the edge.
    task automatic cycle(input bit wv, input int a, input logic [31:0] d,
                         input bit rv, input int st, input logic [7:0] tg);
        dcr_wr_valid = wv; dcr_wr_addr = 12'(a); dcr_wr_data = d;
        req_valid = rv; req_stage = 1'(st); req_tag = tg;
        g_exp = model_pack(st);
        #1;
        g_acc = rv && req_ready;
        @(posedge clk);
        if (wv) model_write(a, d);
        #1;
        dcr_wr_valid = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cycle(1'b1, a, d, 1'b0, 0, 8'h00);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b need 0", rsp_valid); end
        checks++; if (rsp_dcrs !== '0) begin errors++; $display("FAIL reset_rsp_dcrs got %h need 0", rsp_dcrs); end
        checks++; if (rsp_tag !== 8'h00) begin errors++; $display("FAIL reset_rsp_tag got %h need 00", rsp_tag); end
        checks++; if (bad_wr_count !== 8'd0) begin errors++; $display("FAIL reset_bad_count got %0d need 0", bad_wr_count); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b need 1", req_ready); end
    endtask

    task automatic test_basic();
        wr(BASE + 0, 32'd1);
        wr(BASE + 1, 32'h8000_0000);
        wr(BASE + 2, 32'h0009_0008);
        wr(BASE + 3, 32'd2);
        wr(BASE + 4, 32'd1);
        wr(BASE + 5, 32'h0002_0001);
        wr(BASE + 9, 32'h123);
        cycle(1'b0, 0, 0, 1'b1, 1, 8'h11);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b need 1", rsp_valid); end
        checks++; if (rsp_dcrs[35:4] !== 32'h8000_0000) begin errors++; $display("FAIL basic_baddr got %h need 80000000", rsp_dcrs[35:4]); end
        checks++; if (rsp_dcrs[47:40] !== 8'h98) begin errors++; $display("FAIL basic_logdims got %h need 98", rsp_dcrs[47:40]); end
        checks++; if (rsp_dcrs[3:0] !== 4'b0101) begin errors++; $display("FAIL basic_fmt_filter got %b need 0101", rsp_dcrs[3:0]); end
        checks++; if (rsp_dcrs[39:36] !== 4'b1001) begin errors++; $display("FAIL basic_wraps got %b need 1001", rsp_dcrs[39:36]); end
        checks++; if (rsp_dcrs[48+23*3 +: 23] !== 23'h123) begin errors++; $display("FAIL basic_mipoff3 got %h need 123", rsp_dcrs[48+23*3 +: 23]); end
        checks++; if (rsp_dcrs !== g_exp) begin errors++; $display("FAIL basic_stage1 got %h need %h", rsp_dcrs, g_exp); end
        checks++; if (rsp_tag !== 8'h11) begin errors++; $display("FAIL basic_tag got %h need 11", rsp_tag); end
        cycle(1'b0, 0, 0, 1'b1, 0, 8'h12);
        checks++; if (rsp_dcrs !== '0) begin errors++; $display("FAIL basic_stage0_zero got %h need 0", rsp_dcrs); end
        cycle(1'b0, 0, 0, 1'b0, 0, 8'h00);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_idle got %b need 0", rsp_valid); end
    endtask

    task automatic test_same_cycle();
        wr(BASE + 0, 32'd0);
        cycle(1'b1, BASE + 1, 32'hA, 1'b1, 0, 8'h21);
        checks++; if (rsp_dcrs[35:4] !== 32'h0) begin errors++; $display("FAIL same_cycle_old got %h need 0", rsp_dcrs[35:4]); end
        cycle(1'b0, 0, 0, 1'b1, 0, 8'h22);
        checks++; if (rsp_dcrs[35:4] !== 32'hA) begin errors++; $display("FAIL same_cycle_new got %h need a", rsp_dcrs[35:4]); end
        cycle(1'b0, 0, 0, 1'b0, 0, 8'h00);
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        cycle(1'b0, 0, 0, 1'b1, 1, 8'd5);
        req_valid = 1'b1; req_stage = 1'b1; req_tag = 8'd6;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (rsp_tag !== 8'd5 || rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold tag %0d valid %b need 5/1", rsp_tag, rsp_valid); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b need 0", req_ready); end
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (rsp_tag !== 8'd5 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release tag %0d ready %b need 5/1", rsp_tag, req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (rsp_tag !== 8'd6 || rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_second tag %0d valid %b need 6/1", rsp_tag, rsp_valid); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b need 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        int st;
        for (int i = 0; i < 10; i++) begin
            st = int'($urandom_range(0, 1));
            cycle(1'b0, 0, 0, 1'b1, st, 8'(40 + i));
            checks++; if (rsp_valid !== 1'b1 || rsp_tag !== 8'(40 + i)) begin errors++; $display("FAIL b2b_%0d valid %b tag %0d need 1/%0d", i, rsp_valid, rsp_tag, 40 + i); end
            checks++; if (rsp_dcrs !== g_exp) begin errors++; $display("FAIL b2b_data_%0d got %h need %h", i, rsp_dcrs, g_exp); end
        end
        cycle(1'b0, 0, 0, 1'b0, 0, 8'h00);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b need 0", rsp_valid); end
    endtask

    task automatic test_random();
        int r, a, st;
        bit wv;
        logic [31:0] d;
        for (int i = 0; i < 300; i++) begin
            r  = int'($urandom_range(0, 99));
            wv = (r < 80);
            d  = $urandom;
            if (r < 6)       begin a = BASE; d = 32'($urandom_range(0, 3)); end
            else if (r < 10) a = int'($urandom_range(0, 'hFF));
            else if (r < 13) a = BASE + 18 + int'($urandom_range(0, 40));
            else             a = BASE + int'($urandom_range(1, 17));
            st = int'($urandom_range(0, 1));
            cycle(wv, a, d, 1'b1, st, 8'(i));
            checks++; if (rsp_dcrs !== g_exp || rsp_tag !== 8'(i)) begin errors++; $display("FAIL rand_%0d got %h tag %0d need %h tag %0d", i, rsp_dcrs, rsp_tag, g_exp, i); end
            checks++; if (bad_wr_count !== 8'(m_bad)) begin errors++; $display("FAIL rand_bad_%0d got %0d need %0d", i, bad_wr_count, m_bad); end
        end
        cycle(1'b0, 0, 0, 1'b0, 0, 8'h00);
    endtask

    task automatic test_bad_stage();
        logic [DCRS_BITS-1:0] e0, e1;
        wr(BASE + 0, 32'd3);
        for (int i = 0; i < 300; i++)
            wr(BASE + int'($urandom_range(1, 17)), $urandom);
        checks++; if (bad_wr_count !== 8'd255) begin errors++; $display("FAIL bad_saturate got %0d need 255", bad_wr_count); end
        wr(BASE + 'h40, 32'hFFFF_FFFF);
        checks++; if (bad_wr_count !== 8'd255) begin errors++; $display("FAIL bad_outside got %0d need 255", bad_wr_count); end
        e0 = model_pack(0);
        e1 = model_pack(1);
        cycle(1'b0, 0, 0, 1'b1, 0, 8'h50);
        checks++; if (rsp_dcrs !== e0) begin errors++; $display("FAIL bad_stage0_kept got %h need %h", rsp_dcrs, e0); end
        cycle(1'b0, 0, 0, 1'b1, 1, 8'h51);
        checks++; if (rsp_dcrs !== e1) begin errors++; $display("FAIL bad_stage1_kept got %h need %h", rsp_dcrs, e1); end
        cycle(1'b0, 0, 0, 1'b0, 0, 8'h00);
        wr(BASE + 0, 32'd0);
        wr(BASE + 1, 32'h55);
        checks++; if (bad_wr_count !== 8'd255) begin errors++; $display("FAIL bad_recover_count got %0d need 255", bad_wr_count); end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        cycle(1'b0, 0, 0, 1'b1, 0, 8'h77);
        checks++; if (rsp_valid !== 1'b1 || rsp_dcrs[35:4] !== 32'h55) begin errors++; $display("FAIL rm_loaded valid %b baddr %h need 1/55", rsp_valid, rsp_dcrs[35:4]); end
        #2 reset = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_async_valid got %b need 0", rsp_valid); end
        checks++; if (rsp_dcrs !== '0 || rsp_tag !== 8'h00) begin errors++; $display("FAIL rm_async_data got %h tag %h need 0", rsp_dcrs, rsp_tag); end
        model_reset();
        rsp_ready = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        cycle(1'b0, 0, 0, 1'b1, 0, 8'h78);
        checks++; if (rsp_valid !== 1'b1 || rsp_dcrs !== '0) begin errors++; $display("FAIL rm_after valid %b got %h need 1/0", rsp_valid, rsp_dcrs); end
        checks++; if (bad_wr_count !== 8'd0) begin errors++; $display("FAIL rm_bad_count got %0d need 0", bad_wr_count); end
        cycle(1'b0, 0, 0, 1'b0, 0, 8'h00);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_cycle();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_bad_stage();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tex_dcr_unit.md
# tex_dcr_unit

Device-configuration-register (DCR) front end for the texture unit. It receives the host's DCR write stream, decodes each write into per-stage texture state (mip offsets, log dimensions, wrap modes, base address, format, filter), and serves that state back to the texture pipeline as a packed texture-state record through a valid/ready lookup port. It sits between the DCR bus and the texture sampler's address-generation stage.

## Interface
- NUM_STAGES, 2: number of texture stages held; STAGE_BITS = max(1, clog2(NUM_STAGES)).
- LOD_MAX, 11: highest mip level; LOD_MAX+1 mip-offset entries per stage.
- LOD_BITS, 4: width of each log-dimension field.
- DIM_BITS, 11: MIPOFF_BITS = 2*DIM_BITS+1 (23).
- DCR_BASE, 12'h100: first DCR address owned by this block.
- TAG_WIDTH, 8: lookup tag width.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- dcr_wr_valid  in  1  DCR write strobe, one write per cycle, no backpressure.
- dcr_wr_addr  in  12  DCR address.
- dcr_wr_data  in  32  DCR data.
- req_valid  in  1  lookup request.
- req_stage  in  STAGE_BITS  stage to read.
- req_tag  in  TAG_WIDTH  opaque tag.
- req_ready  out  1  lookup accepted when req_valid && req_ready.
- rsp_valid  out  1  response valid.
- rsp_dcrs  out  DCRS_BITS  packed state; MSB→LSB: mipoff[LOD_MAX..0], logdims[v,u], wraps[v,u], baddr[31:0], format[2:0], filter[0]. DCRS_BITS = (LOD_MAX+1)*MIPOFF_BITS + 2*LOD_BITS + 4 + 32 + 3 + 1 (324 with defaults).
- rsp_tag  out  TAG_WIDTH  tag of the request.
- rsp_ready  in  1  consumer accepts response.
- bad_wr_count  out  8  saturating count of dropped DCR writes.

## Operation
- Offsets from DCR_BASE: 0 STAGE (data[STAGE_BITS-1:0] → stage_sel); 1 ADDR (baddr = data); 2 LOGDIM (u = data[LOD_BITS-1:0], v = data[16+LOD_BITS-1:16]); 3 FORMAT (data[2:0]); 4 FILTER (data[0]); 5 WRAP (u = data[1:0], v = data[17:16]); 6..6+LOD_MAX MIPOFF[off-6] = data[MIPOFF_BITS-1:0].
- Offsets 1..6+LOD_MAX write the stage selected by stage_sel. Upper data bits are ignored.
- A STAGE write with value ≥ NUM_STAGES is stored. Subsequent field writes are then dropped and counted until a valid stage is selected.
- Dropped writes: address in DCR_BASE..DCR_BASE+6+LOD_MAX with an out-of-range stage_sel. Addresses outside the window are silently ignored, not counted; they belong to other units.
- bad_wr_count increments by 1 per dropped write and saturates at 255.
- Lookup: on acceptance, the state of req_stage, as it stands before this cycle's write, is registered into rsp_dcrs with rsp_tag. A req_stage ≥ NUM_STAGES returns all-zero state.
- Output stage is a single register: req_ready = !rsp_valid || rsp_ready.

## Timing
- Reset (async assert): all stage state 0, stage_sel 0, rsp_valid 0, rsp_dcrs 0, rsp_tag 0, bad_wr_count 0. No lookup in flight survives reset.
- DCR write takes effect at the clock edge. It is visible to a lookup accepted in the next cycle or later.
- Simultaneous write and lookup to the same stage: the response carries the old value.
- Lookup latency 1 cycle: accepted at edge N, rsp_valid high after edge N.
- While rsp_valid && !rsp_ready, rsp_dcrs and rsp_tag are held stable and req_ready = 0.
- When rsp_valid && rsp_ready && req_valid, a new response loads in the same edge. This gives a throughput of 1 per cycle.
- rsp_valid deasserts after a handshake with no new request.

## Test plan
- Select stage 1, then write ADDR=0x8000_0000, LOGDIM=0x0009_0008, FORMAT=2, FILTER=1, WRAP=0x0002_0001, MIPOFF[3]=0x123. Lookup stage 1 → baddr 0x80000000, logdims u=8/v=9, format 2, filter 1, wraps u=1/v=2, mipoff[3]=0x123. Lookup stage 0 → all zero.
- Write ADDR=0xA to stage 0 in the same cycle as a stage-0 lookup → response baddr 0. An immediate second lookup → 0xA.
- Hold rsp_ready=0 for 3 cycles with req_valid=1 and tags 5,6 → rsp_tag stays 5 and req_ready=0. Release → tag 5, then tag 6 on consecutive cycles.
- STAGE=3 (NUM_STAGES=2), then 300 field writes → bad_wr_count = 255, and stage 0/1 state is unchanged. Write to DCR_BASE+0x40 → counter unchanged.
- Assert reset mid-stream while rsp_valid=1 with nonzero state → rsp_valid 0 immediately (asynchronous), and a lookup after release returns zeros.
- Back-to-back lookups with rsp_ready=1 for 10 cycles → 10 responses in 10 consecutive cycles, tags in order.
